key_conditioner: RTL and testbench

- Input-side counterpart to the clock top's display/beep output path. Conditions the raw push-buttons (Pulse, QD, CLR) into clean, per-key event pulses for the mode/setting logic.
- Per key, in the clk_1khz domain, it performs:
  - polarity normalisation;
  - 2-flop synchronisation;
  - debounce;
  - press, release, long-press and auto-repeat generation.
- One instance serves all front-panel keys. Keys are fully independent.

---
 rtl/key_conditioner.sv | 196 +++++++++++++++++++
 tb/tb_key_conditioner.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: turns raw front-panel push-buttons into clean per-key
// events. Each key is handled independently by the same chain of stages:
// polarity normalisation, a 2-flop synchroniser, a debouncer and an event
// FSM that produces press, release, long-press and auto-repeat pulses.
// Every output comes straight from a flop, so downstream logic never sees
// combinational glitches.
module key_conditioner #(
    parameter int                  NUM_KEYS    = 3,
    parameter logic [NUM_KEYS-1:0] INVERT_MASK = 3'b100,
    parameter int                  DEBOUNCE_MS = 20,
    parameter int                  LONG_MS     = 800,
    parameter int                  REPEAT_MS   = 200
) (
    input  logic                clk_1khz,
    input  logic                switch_clr,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_step
);

    // Counter widths. The debounce counter must hold DEBOUNCE_MS, the hold
    // counter LONG_MS-1 and the repeat counter REPEAT_MS-1. The repeat width
    // is sized from REPEAT_MS+1 so that REPEAT_MS = 1 still gets one bit.
    localparam int DB_W = $clog2(DEBOUNCE_MS + 1);
    localparam int HC_W = $clog2(LONG_MS);
    localparam int RC_W = $clog2(REPEAT_MS + 1);

    // Terminal counts. Reaching one of these triggers the action on the
    // following edge.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(LONG_MS - 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REPEAT_MS - 1);

    // Per-key event states. LONG is only left by a release.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } key_state_t;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            // Synchroniser and debouncer state.
            logic            w_norm;
            logic            r_sync1;
            logic            r_sync2;
            logic            r_level;
            logic [DB_W-1:0] r_db;
            logic            w_differs;
            logic            w_rise;
            logic            w_fall;

            // Event FSM state, counters and registered pulses.
            key_state_t      r_state;
            key_state_t      w_state_next;
            logic [HC_W-1:0] r_hc;
            logic [HC_W-1:0] w_hc_next;
            logic [RC_W-1:0] r_rc;
            logic [RC_W-1:0] w_rc_next;
            logic            w_press_next;
            logic            w_release_next;
            logic            w_long_next;
            logic            w_step_next;
            logic            r_press;
            logic            r_release;
            logic            r_long;
            logic            r_step;

            // After normalisation, 1 always means pressed. The synchroniser
            // therefore resets to 0, which is the released level.
            assign w_norm = key_raw[gi] ^ INVERT_MASK[gi];

            // Two-flop synchroniser for the asynchronous button level.
            always_ff @(posedge clk_1khz or negedge switch_clr) begin
                if (!switch_clr) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                end else begin
                    r_sync1 <= w_norm;
                    r_sync2 <= r_sync1;
                end
            end

            // The level flips on the edge where the counter sits at its
            // terminal count and the input still disagrees. These strobes are
            // high in the cycle before key_level changes, so the event FSM can
            // register its pulses on the same edge as the level.
            assign w_differs = (r_sync2 != r_level);
            assign w_rise    = w_differs && (r_db == DB_LAST) && !r_level;
            assign w_fall    = w_differs && (r_db == DB_LAST) &&  r_level;

            // Debouncer: the level follows the synced input only after the
            // input has disagreed with it for DEBOUNCE_MS consecutive cycles.
            // Any agreement restarts the count.
            always_ff @(posedge clk_1khz or negedge switch_clr) begin
                if (!switch_clr) begin
                    r_level <= 1'b0;
                    r_db    <= '0;
                end else if (!w_differs) begin
                    r_db <= '0;
                end else if (r_db == DB_LAST) begin
                    r_level <= ~r_level;
                    r_db    <= '0;
                end else begin
                    r_db <= r_db + DB_W'(1);
                end
            end

            // Next-state logic for the event FSM. A release overrides
            // everything else, so a long or step threshold that lands on the
            // release edge is dropped.
            always_comb begin
                w_state_next   = r_state;
                w_hc_next      = r_hc;
                w_rc_next      = r_rc;
                w_press_next   = 1'b0;
                w_release_next = 1'b0;
                w_long_next    = 1'b0;
                w_step_next    = 1'b0;

                if (w_fall) begin
                    w_state_next   = ST_IDLE;
                    w_hc_next      = '0;
                    w_rc_next      = '0;
                    w_release_next = 1'b1;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (w_rise) begin
                                w_state_next = ST_HELD;
                                w_hc_next    = '0;
                                w_press_next = 1'b1;
                                w_step_next  = 1'b1;
                            end
                        end
                        ST_HELD: begin
                            if (r_hc == HC_LAST) begin
                                w_state_next = ST_LONG;
                                w_rc_next    = '0;
                                w_long_next  = 1'b1;
                                w_step_next  = 1'b1;
                            end else begin
                                w_hc_next = r_hc + HC_W'(1);
                            end
                        end
                        ST_LONG: begin
                            if (r_rc == RC_LAST) begin
                                w_rc_next   = '0;
                                w_step_next = 1'b1;
                            end else begin
                                w_rc_next = r_rc + RC_W'(1);
                            end
                        end
                        default: begin
                            w_state_next = ST_IDLE;
                            w_hc_next    = '0;
                            w_rc_next    = '0;
                        end
                    endcase
                end
            end

            // Register the FSM state, its counters and the output pulses.
            always_ff @(posedge clk_1khz or negedge switch_clr) begin
                if (!switch_clr) begin
                    r_state   <= ST_IDLE;
                    r_hc      <= '0;
                    r_rc      <= '0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_long    <= 1'b0;
                    r_step    <= 1'b0;
                end else begin
                    r_state   <= w_state_next;
                    r_hc      <= w_hc_next;
                    r_rc      <= w_rc_next;
                    r_press   <= w_press_next;
                    r_release <= w_release_next;
                    r_long    <= w_long_next;
                    r_step    <= w_step_next;
                end
            end

            assign key_level[gi]   = r_level;
            assign key_press[gi]   = r_press;
            assign key_release[gi] = r_release;
            assign key_long[gi]    = r_long;
            assign key_step[gi]    = r_step;
        end
    endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner at its default parameters. Each task
// drives one scenario and checks all outputs on every cycle against
// hand-derived timing. Cycle i counts the clock edges since the task's first
// stimulus change; a raw change made just after edge 0 reaches key_level on
// edge 22.
module tb_key_conditioner;

    logic       clk_1khz;
    logic       switch_clr;
    logic [2:0] key_raw;
    logic [2:0] key_level;
    logic [2:0] key_press;
    logic [2:0] key_release;
    logic [2:0] key_long;
    logic [2:0] key_step;

    int checks;
    int failures;

    key_conditioner dut (
        .clk_1khz    (clk_1khz),
        .switch_clr  (switch_clr),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_step    (key_step)
    );

    initial clk_1khz = 1'b0;
    always #5 clk_1khz = ~clk_1khz;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_1khz);
        #1;
    endtask

    // Outputs held in reset, then quiet for a while after reset is released.
    task automatic test_reset();
        logic [14:0] obs;
        switch_clr = 1'b0;
        key_raw    = 3'b100;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 2) key_raw = 3'b001;
            obs = {key_level, key_press, key_release, key_long, key_step};
            checks++;
            if (obs !== 15'd0) begin
                failures++;
                $display("FAIL reset_hold cycle %0d: got %b expected %b", i, obs, 15'd0);
            end
        end
        key_raw    = 3'b100;
        switch_clr = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            obs = {key_level, key_press, key_release, key_long, key_step};
            checks++;
            if (obs !== 15'd0) begin
                failures++;
                $display("FAIL reset_quiet cycle %0d: got %b expected %b", i, obs, 15'd0);
            end
        end
    endtask

    // Clean press of key 0 at 0, clean release at 200.
    task automatic test_clean_press();
        logic [14:0] obs;
        logic [2:0]  e_lvl, e_prs, e_rel, e_lng, e_stp;
        key_raw[0] = 1'b1;
        for (int i = 1; i <= 240; i++) begin
            tick();
            e_lvl = '0; e_prs = '0; e_rel = '0; e_lng = '0; e_stp = '0;
            e_lvl[0] = (i >= 22) && (i < 222);
            e_prs[0] = (i == 22);
            e_stp[0] = (i == 22);
            e_rel[0] = (i == 222);
            obs = {key_level, key_press, key_release, key_long, key_step};
            checks++;
            if (obs !== {e_lvl, e_prs, e_rel, e_lng, e_stp}) begin
                failures++;
                $display("FAIL clean_press cycle %0d: got %b expected %b",
                         i, obs, {e_lvl, e_prs, e_rel, e_lng, e_stp});
            end
            if (i == 200) key_raw[0] = 1'b0;
        end
    endtask

    // Key 1 bounces every 5 cycles, settles high at 60, then sees a
    // 15-cycle glitch (100..115) and a clean release at 150.
    task automatic test_bounce();
        logic [14:0] obs;
        logic [2:0]  e_lvl, e_prs, e_rel, e_lng, e_stp;
        key_raw[1] = 1'b1;
        for (int i = 1; i <= 190; i++) begin
            tick();
            e_lvl = '0; e_prs = '0; e_rel = '0; e_lng = '0; e_stp = '0;
            e_lvl[1] = (i >= 82) && (i < 172);
            e_prs[1] = (i == 82);
            e_stp[1] = (i == 82);
            e_rel[1] = (i == 172);
            obs = {key_level, key_press, key_release, key_long, key_step};
            checks++;
            if (obs !== {e_lvl, e_prs, e_rel, e_lng, e_stp}) begin
                failures++;
                $display("FAIL bounce cycle %0d: got %b expected %b",
                         i, obs, {e_lvl, e_prs, e_rel, e_lng, e_stp});
            end
            if (i < 60 && (i % 5) == 0) key_raw[1] = ~key_raw[1];
            if (i == 60)  key_raw[1] = 1'b1;
            if (i == 100) key_raw[1] = 1'b0;
            if (i == 115) key_raw[1] = 1'b1;
            if (i == 150) key_raw[1] = 1'b0;
        end
    endtask

    // Key 0 held for 1500 cycles after its press at 22.
    task automatic test_long_repeat();
        logic [14:0] obs;
        logic [2:0]  e_lvl, e_prs, e_rel, e_lng, e_stp;
        key_raw[0] = 1'b1;
        for (int i = 1; i <= 1650; i++) begin
            tick();
            e_lvl = '0; e_prs = '0; e_rel = '0; e_lng = '0; e_stp = '0;
            e_lvl[0] = (i >= 22) && (i < 1544);
            e_prs[0] = (i == 22);
            e_lng[0] = (i == 822);
            e_stp[0] = (i == 22) || (i == 822) || (i == 1022) ||
                       (i == 1222) || (i == 1422);
            e_rel[0] = (i == 1544);
            obs = {key_level, key_press, key_release, key_long, key_step};
            checks++;
            if (obs !== {e_lvl, e_prs, e_rel, e_lng, e_stp}) begin
                failures++;
                $display("FAIL long_repeat cycle %0d: got %b expected %b",
                         i, obs, {e_lvl, e_prs, e_rel, e_lng, e_stp});
            end
            if (i == 1522) key_raw[0] = 1'b0;
        end
    endtask

    // Active-low key 2 alone, then keys 0 and 2 pressed and released together.
    task automatic test_active_low_simul();
        logic [14:0] obs;
        logic [2:0]  e_lvl, e_prs, e_rel, e_lng, e_stp;
        key_raw[2] = 1'b0;
        for (int i = 1; i <= 190; i++) begin
            tick();
            e_lvl = '0; e_prs = '0; e_rel = '0; e_lng = '0; e_stp = '0;
            e_lvl[2] = ((i >= 22) && (i < 72)) || ((i >= 122) && (i < 172));
            e_prs[2] = (i == 22) || (i == 122);
            e_stp[2] = (i == 22) || (i == 122);
            e_rel[2] = (i == 72) || (i == 172);
            e_lvl[0] = (i >= 122) && (i < 172);
            e_prs[0] = (i == 122);
            e_stp[0] = (i == 122);
            e_rel[0] = (i == 172);
            obs = {key_level, key_press, key_release, key_long, key_step};
            checks++;
            if (obs !== {e_lvl, e_prs, e_rel, e_lng, e_stp}) begin
                failures++;
                $display("FAIL active_low_simul cycle %0d: got %b expected %b",
                         i, obs, {e_lvl, e_prs, e_rel, e_lng, e_stp});
            end
            if (i == 50)  key_raw = 3'b100;
            if (i == 100) key_raw = 3'b001;
            if (i == 150) key_raw = 3'b100;
        end
    endtask

    // Key 0 held through a 3-cycle reset pulse 500 cycles after its press.
    task automatic test_reset_mid_hold();
        logic [14:0] obs;
        logic [2:0]  e_lvl, e_prs, e_rel, e_lng, e_stp;
        key_raw[0] = 1'b1;
        for (int i = 1; i <= 522; i++) begin
            tick();
            e_lvl = '0; e_prs = '0; e_rel = '0; e_lng = '0; e_stp = '0;
            e_lvl[0] = (i >= 22);
            e_prs[0] = (i == 22);
            e_stp[0] = (i == 22);
            obs = {key_level, key_press, key_release, key_long, key_step};
            checks++;
            if (obs !== {e_lvl, e_prs, e_rel, e_lng, e_stp}) begin
                failures++;
                $display("FAIL pre_reset_hold cycle %0d: got %b expected %b",
                         i, obs, {e_lvl, e_prs, e_rel, e_lng, e_stp});
            end
        end
        switch_clr = 1'b0;
        #1;
        obs = {key_level, key_press, key_release, key_long, key_step};
        checks++;
        if (obs !== 15'd0) begin
            failures++;
            $display("FAIL async_reset_immediate: got %b expected %b", obs, 15'd0);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            obs = {key_level, key_press, key_release, key_long, key_step};
            checks++;
            if (obs !== 15'd0) begin
                failures++;
                $display("FAIL async_reset_hold cycle %0d: got %b expected %b", i, obs, 15'd0);
            end
        end
        switch_clr = 1'b1;
        for (int i = 1; i <= 860; i++) begin
            tick();
            e_lvl = '0; e_prs = '0; e_rel = '0; e_lng = '0; e_stp = '0;
            e_lvl[0] = (i >= 22) && (i < 852);
            e_prs[0] = (i == 22);
            e_lng[0] = (i == 822);
            e_stp[0] = (i == 22) || (i == 822);
            e_rel[0] = (i == 852);
            obs = {key_level, key_press, key_release, key_long, key_step};
            checks++;
            if (obs !== {e_lvl, e_prs, e_rel, e_lng, e_stp}) begin
                failures++;
                $display("FAIL post_reset_hold cycle %0d: got %b expected %b",
                         i, obs, {e_lvl, e_prs, e_rel, e_lng, e_stp});
            end
            if (i == 830) key_raw[0] = 1'b0;
        end
    endtask

    // Release lands on the long threshold: release wins, no long or step.
    task automatic test_release_at_long();
        logic [14:0] obs;
        logic [2:0]  e_lvl, e_prs, e_rel, e_lng, e_stp;
        key_raw[0] = 1'b1;
        for (int i = 1; i <= 860; i++) begin
            tick();
            e_lvl = '0; e_prs = '0; e_rel = '0; e_lng = '0; e_stp = '0;
            e_lvl[0] = (i >= 22) && (i < 822);
            e_prs[0] = (i == 22);
            e_stp[0] = (i == 22);
            e_rel[0] = (i == 822);
            obs = {key_level, key_press, key_release, key_long, key_step};
            checks++;
            if (obs !== {e_lvl, e_prs, e_rel, e_lng, e_stp}) begin
                failures++;
                $display("FAIL release_at_long cycle %0d: got %b expected %b",
                         i, obs, {e_lvl, e_prs, e_rel, e_lng, e_stp});
            end
            if (i == 800) key_raw[0] = 1'b0;
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        switch_clr = 1'b0;
        key_raw    = 3'b100;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_repeat();
        test_active_low_simul();
        test_reset_mid_hold();
        test_release_at_long();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
